// File: rtl/dpll_pkg.sv
// Constants and helpers shared by the DPLL blocks: the loop filter, this DCO
// and the full-model top all take their control-word width from here.
package dpll_pkg;

    localparam int CTRL_W        = 20;
    localparam int CTRL_MID      = 1 << (CTRL_W - 1);
    localparam int ACC_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        TW_IN_RANGE,
        TW_BELOW,
        TW_ABOVE
    } tw_range_e;

    // Classifies a signed raw tuning word against the legal [lo, hi] window.
    function automatic tw_range_e tw_clamp(
        input logic signed [63:0] raw,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        tw_range_e r;
        if (raw < lo) begin
            r = TW_BELOW;
        end else if (raw > hi) begin
            r = TW_ABOVE;
        end else begin
            r = TW_IN_RANGE;
        end
        return r;
    endfunction

endpackage

// File: rtl/dco_period_meter.sv
// Measures the clk cycles between successive edge pulses; the first edge after
// reset only arms the meter.
module dco_period_meter #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             edge_pulse,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             seen_q, seen_d;

    // The counter saturates so an over-long period reads back as all-ones.
    always_comb begin
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + PER_W'(1);
        period_d = period_q;
        valid_d  = 1'b0;
        seen_d   = seen_q;
        if (edge_pulse) begin
            cnt_d  = PER_W'(1);
            seen_d = 1'b1;
            if (seen_q) begin
                period_d = cnt_q;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;

endmodule

// File: rtl/dco_nco.sv
// Digitally-controlled oscillator: maps the loop filter's offset-binary control
// word onto a clamped tuning word and runs a phase accumulator to make clk_vco.
module dco_nco #(
    parameter int CTRL_W      = dpll_pkg::CTRL_W,
    parameter int ACC_W       = dpll_pkg::ACC_W_DEFAULT,
    parameter int CENTER_WORD = 524288,
    parameter int GAIN_SHIFT  = 4,
    parameter int TW_MIN      = 1,
    parameter int TW_MAX      = 8388607,
    parameter int PER_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] dig_ctrl_voltage,
    input  logic              ctrl_valid,
    input  logic              hold,
    output logic              clk_vco,
    output logic              edge_pulse,
    output logic [ACC_W-1:0]  tuning_word,
    output logic              clamped,
    output logic [PER_W-1:0]  period,
    output logic              period_valid
);

    import dpll_pkg::tw_range_e;
    import dpll_pkg::tw_clamp;

    localparam int RAW_W = ACC_W + 2;
    localparam logic [CTRL_W:0] MID = {2'b01, {(CTRL_W - 1){1'b0}}};

    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic                     pending_q, pending_d;
    logic [ACC_W-1:0]         tw_q, tw_d;
    logic                     clamped_q, clamped_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic                     clk_vco_q, clk_vco_d;
    logic                     edge_q, edge_d;

    logic signed [CTRL_W:0]   offset;
    logic signed [CTRL_W:0]   delta;
    logic signed [RAW_W-1:0]  raw;
    tw_range_e                range_sel;
    logic [ACC_W-1:0]         clamp_word;

    // Offset-binary control becomes a signed offset, scaled down and added to
    // the centre word; the result is limited to the legal tuning range.
    always_comb begin
        offset    = $signed({1'b0, ctrl_q}) - $signed(MID);
        delta     = offset >>> GAIN_SHIFT;
        raw       = $signed(RAW_W'(CENTER_WORD))
                  + $signed({{(RAW_W - CTRL_W - 1){delta[CTRL_W]}}, delta});
        range_sel = tw_clamp($signed({{(64 - RAW_W){raw[RAW_W-1]}}, raw}),
                             64'(TW_MIN), 64'(TW_MAX));
        case (range_sel)
            dpll_pkg::TW_BELOW: clamp_word = ACC_W'(TW_MIN);
            dpll_pkg::TW_ABOVE: clamp_word = ACC_W'(TW_MAX);
            default:            clamp_word = raw[ACC_W-1:0];
        endcase
    end

    // A capture in the same cycle as a pending update simply replaces the word
    // for the next computation; hold freezes both capture and update.
    always_comb begin
        ctrl_d    = ctrl_q;
        pending_d = pending_q;
        tw_d      = tw_q;
        clamped_d = clamped_q;
        if (pending_q && !hold) begin
            tw_d      = clamp_word;
            clamped_d = (range_sel != dpll_pkg::TW_IN_RANGE);
            pending_d = 1'b0;
        end
        if (ctrl_valid && !hold) begin
            ctrl_d    = dig_ctrl_voltage;
            pending_d = 1'b1;
        end
        acc_d     = acc_q + tw_q;
        clk_vco_d = acc_q[ACC_W-1];
        edge_d    = acc_q[ACC_W-1] & ~clk_vco_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= MID[CTRL_W-1:0];
            pending_q <= 1'b0;
            tw_q      <= ACC_W'(CENTER_WORD);
            clamped_q <= 1'b0;
            acc_q     <= '0;
            clk_vco_q <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            tw_q      <= tw_d;
            clamped_q <= clamped_d;
            acc_q     <= acc_d;
            clk_vco_q <= clk_vco_d;
            edge_q    <= edge_d;
        end
    end

    dco_period_meter #(
        .PER_W (PER_W)
    ) u_period_meter (
        .clk          (clk),
        .rst          (rst),
        .edge_pulse   (edge_q),
        .period       (period),
        .period_valid (period_valid)
    );

    assign clk_vco     = clk_vco_q;
    assign edge_pulse  = edge_q;
    assign tuning_word = tw_q;
    assign clamped     = clamped_q;

endmodule

// File: tb/tb_dco_nco.sv
// Directed bench for dco_nco: default build plus two clamp-oriented builds that
// share the same stimulus.
module tb_dco_nco;
    import dpll_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] dig_ctrl_voltage;
    logic        ctrl_valid;
    logic        hold;

    logic        clk_vco, edge_pulse, clamped, period_valid;
    logic [23:0] tuning_word;
    logic [15:0] period;

    logic        g0_clk_vco, g0_edge_pulse, g0_clamped, g0_period_valid;
    logic [23:0] g0_tuning_word;
    logic [15:0] g0_period;

    logic        hi_clk_vco, hi_edge_pulse, hi_clamped, hi_period_valid;
    logic [23:0] hi_tuning_word;
    logic [15:0] hi_period;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dco_nco u_dut (
        .clk(clk), .rst(rst), .dig_ctrl_voltage(dig_ctrl_voltage),
        .ctrl_valid(ctrl_valid), .hold(hold), .clk_vco(clk_vco),
        .edge_pulse(edge_pulse), .tuning_word(tuning_word), .clamped(clamped),
        .period(period), .period_valid(period_valid)
    );

    dco_nco #(.GAIN_SHIFT(0)) u_dut_g0 (
        .clk(clk), .rst(rst), .dig_ctrl_voltage(dig_ctrl_voltage),
        .ctrl_valid(ctrl_valid), .hold(hold), .clk_vco(g0_clk_vco),
        .edge_pulse(g0_edge_pulse), .tuning_word(g0_tuning_word), .clamped(g0_clamped),
        .period(g0_period), .period_valid(g0_period_valid)
    );

    dco_nco #(.GAIN_SHIFT(0), .CENTER_WORD(8000000)) u_dut_hi (
        .clk(clk), .rst(rst), .dig_ctrl_voltage(dig_ctrl_voltage),
        .ctrl_valid(ctrl_valid), .hold(hold), .clk_vco(hi_clk_vco),
        .edge_pulse(hi_edge_pulse), .tuning_word(hi_tuning_word), .clamped(hi_clamped),
        .period(hi_period), .period_valid(hi_period_valid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives the inputs across one rising edge, returning at the next falling edge.
    task automatic applyStimulus(input logic [19:0] ctrl, input logic valid,
                                 input logic hld);
        dig_ctrl_voltage = ctrl;
        ctrl_valid       = valid;
        hold             = hld;
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    task automatic waitPulse(input int budget, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        while (!ok && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (edge_pulse) ok = 1'b1;
        end
    endtask

    task automatic waitValid(input int budget, output logic [15:0] p, output bit ok);
        ok = 1'b0;
        p  = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (period_valid) begin
                ok = 1'b1;
                p  = period;
            end
        end
    endtask

    initial begin
        int          cyc;
        bit          ok;
        logic [15:0] p;
        int          bad;
        int          timeouts;
        int          sum;

        rst              = 1'b1;
        dig_ctrl_voltage = 20'(CTRL_MID);
        ctrl_valid       = 1'b0;
        hold             = 1'b0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_clk_vco", clk_vco, 0);
            checkOutput("rst_tuning_word", tuning_word, 524288);
            checkOutput("rst_period_valid", period_valid, 0);
        end
        rst = 1'b0;
        waitPulse(40, cyc, ok);
        checkOutput("first_edge_seen", ok, 1);
        checkOutput("first_edge_cycle", cyc, 17);
        checkOutput("first_edge_no_valid", period_valid, 0);
        @(negedge clk);
        checkOutput("first_edge_no_valid_next", period_valid, 0);
        waitValid(100, p, ok);
        checkOutput("first_period_seen", ok, 1);
        checkOutput("first_period", p, 32);

        // Mid-scale control.
        applyStimulus(20'd524288, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("mid_tuning_word", tuning_word, 524288);
        checkOutput("mid_clamped", clamped, 0);
        for (int i = 0; i < 4; i++) begin
            waitValid(100, p, ok);
            checkOutput("mid_period_seen", ok, 1);
            checkOutput("mid_period", p, 32);
        end

        // Minimum control.
        applyStimulus(20'd0, 1'b1, 1'b0);
        checkOutput("min_tw_not_yet", tuning_word, 524288);
        @(negedge clk);
        checkOutput("min_tuning_word", tuning_word, 491520);
        checkOutput("min_clamped", clamped, 0);
        checkOutput("g0_min_tuning_word", g0_tuning_word, 1);
        checkOutput("g0_min_clamped", g0_clamped, 1);
        checkOutput("hi_min_tuning_word", hi_tuning_word, 7475712);
        checkOutput("hi_min_clamped", hi_clamped, 0);
        repeat (2) waitValid(100, p, ok);
        bad = 0; timeouts = 0; sum = 0;
        for (int i = 0; i < 100; i++) begin
            waitValid(100, p, ok);
            if (!ok) begin
                timeouts++;
                break;
            end
            if (p != 16'd34 && p != 16'd35) bad++;
            sum += int'(p);
        end
        checkOutput("min_period_timeout", timeouts, 0);
        checkOutput("min_period_values", bad, 0);
        checkOutput("min_period_mean", (sum >= 3408 && sum <= 3418), 1);

        // Maximum control.
        applyStimulus(20'hFFFFF, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("max_tuning_word", tuning_word, 557055);
        checkOutput("max_clamped", clamped, 0);
        checkOutput("g0_max_tuning_word", g0_tuning_word, 1048575);
        checkOutput("g0_max_clamped", g0_clamped, 0);
        checkOutput("hi_max_tuning_word", hi_tuning_word, 8388607);
        checkOutput("hi_max_clamped", hi_clamped, 1);
        repeat (2) waitValid(100, p, ok);
        bad = 0; timeouts = 0;
        for (int i = 0; i < 20; i++) begin
            waitValid(100, p, ok);
            if (!ok) begin
                timeouts++;
                break;
            end
            if (p != 16'd30 && p != 16'd31) bad++;
        end
        checkOutput("max_period_timeout", timeouts, 0);
        checkOutput("max_period_values", bad, 0);

        // Hold blocks capture entirely.
        applyStimulus(20'd0, 1'b1, 1'b1);
        applyStimulus(20'd0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("hold_tuning_word", tuning_word, 557055);
        checkOutput("g0_hold_tuning_word", g0_tuning_word, 1048575);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("hold_release_tuning_word", tuning_word, 557055);

        // Reset in the middle of a period.
        waitPulse(100, cyc, ok);
        checkOutput("pre_rst_edge_seen", ok, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_clk_vco", clk_vco, 0);
        checkOutput("midrst_edge_pulse", edge_pulse, 0);
        checkOutput("midrst_tuning_word", tuning_word, 524288);
        checkOutput("midrst_clamped", clamped, 0);
        checkOutput("midrst_hi_clamped", hi_clamped, 0);
        checkOutput("midrst_period", period, 0);
        checkOutput("midrst_period_valid", period_valid, 0);
        rst = 1'b0;
        waitPulse(40, cyc, ok);
        checkOutput("midrst_first_edge_cycle", cyc, 17);
        waitValid(100, p, ok);
        checkOutput("midrst_period_seen", ok, 1);
        checkOutput("midrst_first_period", p, 32);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
